// File: rtl/sd_sector_responder_if.sv
// Sector-request bus between the core (sd_* side) and the host byte-stream port.
// slave: the responder; master: the core buffer plus the host that surround it.
interface sd_sector_responder_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [7:0]  sd_buff_din;
  logic        sd_buff_wr;
  logic        host_req;
  logic        host_req_wr;
  logic [31:0] host_req_lba;
  logic        host_start;
  logic [7:0]  host_din;
  logic        host_din_valid;
  logic [7:0]  host_dout;
  logic        host_dout_valid;
  logic        host_dout_ready;
  logic        host_abort;
  logic        busy;

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  host_start, host_din, host_din_valid, host_dout_ready, host_abort,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    output host_req, host_req_wr, host_req_lba, host_dout, host_dout_valid, busy
  );

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    output host_start, host_din, host_din_valid, host_dout_ready, host_abort,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    input  host_req, host_req_wr, host_req_lba, host_dout, host_dout_valid, busy
  );
endinterface

// File: rtl/sd_sector_responder.sv
// Responder side of the core sector-request interface: takes one-sector read or
// write requests from the core and moves the 512 bytes to/from the host stream.
module sd_sector_responder #(
  parameter int unsigned ACK_GAP    = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sd_sector_responder_if.slave  bus
);

  localparam int unsigned GAP_W = $clog2(ACK_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD_XFER,
    S_WR_FETCH,
    S_WR_SEND,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [9:0]       r_cnt;
  logic [GAP_W-1:0] r_gap;
  logic [1:0]       r_lat;
  logic             r_ack;
  logic [8:0]       r_addr;
  logic [7:0]       r_bdout;
  logic             r_bwr;
  logic             r_req;
  logic             r_req_wr;
  logic [31:0]      r_lba;
  logic [7:0]       r_hdout;
  logic             r_hvalid;
  logic             w_abort;

  // Abort only applies while a request or transfer is in flight
  always_comb begin
    w_abort = bus.host_abort &&
              (r_state inside {S_REQ, S_RD_XFER, S_WR_FETCH, S_WR_SEND});
  end

  // Request/transfer sequencer with all outputs registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_gap    <= GAP_W'(ACK_GAP);
      r_lat    <= '0;
      r_ack    <= 1'b0;
      r_addr   <= '0;
      r_bdout  <= '0;
      r_bwr    <= 1'b0;
      r_req    <= 1'b0;
      r_req_wr <= 1'b0;
      r_lba    <= '0;
      r_hdout  <= '0;
      r_hvalid <= 1'b0;
    end else begin
      r_bwr <= 1'b0;
      if (w_abort) begin
        r_ack    <= 1'b0;
        r_req    <= 1'b0;
        r_hvalid <= 1'b0;
        r_gap    <= '0;
        r_state  <= S_GAP;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.sd_rd || bus.sd_wr) begin
              r_lba    <= bus.sd_lba;
              r_req_wr <= ~bus.sd_rd;
              r_req    <= 1'b1;
              r_state  <= S_REQ;
            end
          end
          S_REQ: begin
            if (bus.host_start) begin
              r_req  <= 1'b0;
              r_ack  <= 1'b1;
              r_cnt  <= '0;
              r_addr <= '0;
              r_lat  <= '0;
              r_state <= r_req_wr ? S_WR_FETCH : S_RD_XFER;
            end
          end
          S_RD_XFER: begin
            // Counter reaches 512 on the last strobe; ack drops one cycle later
            if (r_cnt == 10'd512) begin
              r_ack   <= 1'b0;
              r_gap   <= '0;
              r_state <= S_GAP;
            end else if (bus.host_din_valid) begin
              r_bdout <= bus.host_din;
              r_addr  <= r_cnt[8:0];
              r_bwr   <= 1'b1;
              r_cnt   <= r_cnt + 10'd1;
            end
          end
          S_WR_FETCH: begin
            if (r_lat == 2'(RD_LATENCY)) begin
              r_hdout  <= bus.sd_buff_din;
              r_hvalid <= 1'b1;
              r_state  <= S_WR_SEND;
            end else begin
              r_lat <= r_lat + 2'd1;
            end
          end
          S_WR_SEND: begin
            if (bus.host_dout_ready) begin
              r_hvalid <= 1'b0;
              if (r_cnt == 10'd511) begin
                r_ack   <= 1'b0;
                r_gap   <= '0;
                r_state <= S_GAP;
              end else begin
                r_cnt   <= r_cnt + 10'd1;
                r_addr  <= r_cnt[8:0] + 9'd1;
                r_lat   <= '0;
                r_state <= S_WR_FETCH;
              end
            end
          end
          S_GAP: begin
            if (r_gap == GAP_W'(ACK_GAP - 1)) begin
              r_state <= S_IDLE;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.sd_ack          = r_ack;
  assign bus.sd_buff_addr    = r_addr;
  assign bus.sd_buff_dout    = r_bdout;
  assign bus.sd_buff_wr      = r_bwr;
  assign bus.host_req        = r_req;
  assign bus.host_req_wr     = r_req_wr;
  assign bus.host_req_lba    = r_lba;
  assign bus.host_dout       = r_hdout;
  assign bus.host_dout_valid = r_hvalid;
  assign bus.busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_sd_sector_responder.sv
// Directed bench for sd_sector_responder: read/write sectors, back-to-back gap,
// read priority, abort and asynchronous reset. Two instances cover RD_LATENCY 1 and 2.
module tb_sd_sector_responder;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic r_wr_b;
  logic dsel;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  sd_sector_responder_if ifa ();
  sd_sector_responder_if ifb ();

  sd_sector_responder #(.ACK_GAP(8), .RD_LATENCY(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa)
  );
  sd_sector_responder #(.ACK_GAP(8), .RD_LATENCY(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb)
  );

  always #5 clk = ~clk;

  // Instance B only ever sees write requests; other inputs are shared
  assign ifb.sd_lba          = ifa.sd_lba;
  assign ifb.sd_rd           = 1'b0;
  assign ifb.sd_wr           = r_wr_b;
  assign ifb.host_start      = ifa.host_start;
  assign ifb.host_din        = ifa.host_din;
  assign ifb.host_din_valid  = 1'b0;
  assign ifb.host_dout_ready = ifa.host_dout_ready;
  assign ifb.host_abort      = 1'b0;

  // Core buffers hold ~addr; A reads with 1-cycle latency, B with 2
  logic [7:0] a_p1, b_p1, b_p2;
  always @(posedge clk) begin
    a_p1 <= ~ifa.sd_buff_addr[7:0];
    b_p1 <= ~ifb.sd_buff_addr[7:0];
    b_p2 <= b_p1;
  end
  assign ifa.sd_buff_din = a_p1;
  assign ifb.sd_buff_din = b_p2;

  // Views of the selected instance
  logic        v_req, v_req_wr, v_ack, v_hvalid, v_busy;
  logic [31:0] v_lba;
  logic [7:0]  v_dout;
  assign v_req    = dsel ? ifb.host_req        : ifa.host_req;
  assign v_req_wr = dsel ? ifb.host_req_wr     : ifa.host_req_wr;
  assign v_ack    = dsel ? ifb.sd_ack          : ifa.sd_ack;
  assign v_hvalid = dsel ? ifb.host_dout_valid : ifa.host_dout_valid;
  assign v_busy   = dsel ? ifb.busy            : ifa.busy;
  assign v_lba    = dsel ? ifb.host_req_lba    : ifa.host_req_lba;
  assign v_dout   = dsel ? ifb.host_dout       : ifa.host_dout;

  // Strobe log for instance A: expect addr = index, dout = index & 0xFF
  int unsigned n_str = 0, str_bad = 0, str_noack = 0;
  always @(negedge clk) begin
    if (ifa.sd_buff_wr) begin
      if (ifa.sd_buff_addr != n_str[8:0] || ifa.sd_buff_dout != n_str[7:0]) str_bad++;
      if (!ifa.sd_ack) str_noack++;
      n_str++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int c = 0;
    while (!v_req && c < 50) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(v_req), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (v_busy && c < 50) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(v_busy), 32'd0);
  endtask

  task automatic start_xfer(input string tag);
    ifa.host_start = 1'b1;
    @(negedge clk);
    ifa.host_start = 1'b0;
    check(tag, {30'd0, v_ack, v_req}, {30'd0, 1'b1, 1'b0});
  endtask

  task automatic feed_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      ifa.host_din       = 8'(i);
      ifa.host_din_valid = 1'b1;
      @(negedge clk);
      ifa.host_din_valid = 1'b0;
      if (i == 511) check("rd_ack_at_last_strobe", 32'(ifa.sd_ack), 32'd1);
      @(negedge clk);
    end
  endtask

  // Toggle ready every cycle; score each handshake and hold stability
  task automatic write_stream(input string tag, input int nbytes);
    int k = 0, bad = 0, unstable = 0, budget = 20000;
    logic       have_held = 1'b0;
    logic [7:0] held = '0;
    logic [7:0] e;
    while (k < nbytes && budget > 0) begin
      @(negedge clk);
      budget--;
      ifa.host_dout_ready = ~ifa.host_dout_ready;
      if (v_hvalid) begin
        if (have_held && v_dout != held) unstable++;
        if (ifa.host_dout_ready) begin
          e = ~k[7:0];
          if (v_dout != e) bad++;
          k++;
          have_held = 1'b0;
        end else begin
          held = v_dout;
          have_held = 1'b1;
        end
      end
    end
    check({tag, "_count"}, 32'(k), 32'(nbytes));
    check({tag, "_data"}, 32'(bad), 32'd0);
    check({tag, "_stable"}, 32'(unstable), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int low;
    dsel = 1'b0;
    r_wr_b = 1'b0;
    ifa.sd_lba = '0; ifa.sd_rd = 1'b0; ifa.sd_wr = 1'b0;
    ifa.host_start = 1'b0; ifa.host_din = '0; ifa.host_din_valid = 1'b0;
    ifa.host_dout_ready = 1'b0; ifa.host_abort = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs_a", {27'd0, ifa.sd_ack, ifa.host_req, ifa.busy, ifa.sd_buff_wr,
                           ifa.host_dout_valid}, 32'd0);
    check("reset_busy_b", 32'(ifb.busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Full read sector, lba 0x15
    ifa.sd_lba = 32'h15; ifa.sd_rd = 1'b1;
    wait_req("rd_req");
    check("rd_lba", v_lba, 32'h15);
    check("rd_req_wr", 32'(v_req_wr), 32'd0);
    n_str = 0; str_bad = 0; str_noack = 0;
    start_xfer("rd_start");
    ifa.sd_rd = 1'b0;
    feed_bytes(512);
    check("rd_ack_fall", 32'(ifa.sd_ack), 32'd0);
    check("rd_strobes", 32'(n_str), 32'd512);
    check("rd_strobe_data", 32'(str_bad), 32'd0);
    check("rd_strobe_ack", 32'(str_noack), 32'd0);

    // Back-to-back request 5 cycles after ack falls
    low = 1;
    repeat (5) begin
      @(negedge clk);
      low++;
    end
    ifa.sd_lba = 32'h16; ifa.sd_rd = 1'b1;
    while (!ifa.host_req && low < 60) begin
      @(negedge clk);
      if (!ifa.host_req) low++;
    end
    check("b2b_req", 32'(ifa.host_req), 32'd1);
    check("b2b_gap_ok", 32'(low >= 8), 32'd1);
    check("b2b_lba", ifa.host_req_lba, 32'h16);

    // Abort after 100 bytes of the second read
    n_str = 0; str_bad = 0; str_noack = 0;
    start_xfer("ab_start");
    ifa.sd_rd = 1'b0;
    feed_bytes(100);
    ifa.host_abort = 1'b1;
    @(negedge clk);
    ifa.host_abort = 1'b0;
    check("ab_ack_req", {30'd0, ifa.sd_ack, ifa.host_req}, 32'd0);
    check("ab_busy_gap", 32'(ifa.busy), 32'd1);
    feed_bytes(3);
    check("ab_strobes", 32'(n_str), 32'd100);
    check("ab_strobe_data", 32'(str_bad), 32'd0);
    wait_idle("ab_idle");

    // Read wins when both requests are high; abort while in REQ
    ifa.sd_lba = 32'h20; ifa.sd_rd = 1'b1; ifa.sd_wr = 1'b1;
    wait_req("both_req");
    check("both_req_wr", 32'(v_req_wr), 32'd0);
    ifa.sd_rd = 1'b0; ifa.sd_wr = 1'b0;
    ifa.host_abort = 1'b1;
    @(negedge clk);
    ifa.host_abort = 1'b0;
    check("req_abort", 32'(ifa.host_req), 32'd0);
    wait_idle("req_abort_idle");

    // Write sector with backpressure, RD_LATENCY=1
    ifa.sd_lba = 32'h30; ifa.sd_wr = 1'b1;
    wait_req("wra_req");
    check("wra_req_wr", 32'(v_req_wr), 32'd1);
    check("wra_lba", v_lba, 32'h30);
    start_xfer("wra_start");
    ifa.sd_wr = 1'b0;
    write_stream("wra", 512);
    @(negedge clk);
    check("wra_end", {30'd0, v_ack, v_hvalid}, 32'd0);
    ifa.host_dout_ready = 1'b0;
    wait_idle("wra_idle");

    // Same on the RD_LATENCY=2 instance
    dsel = 1'b1;
    ifa.sd_lba = 32'h31; r_wr_b = 1'b1;
    wait_req("wrb_req");
    check("wrb_lba", v_lba, 32'h31);
    start_xfer("wrb_start");
    r_wr_b = 1'b0;
    write_stream("wrb", 512);
    @(negedge clk);
    check("wrb_end", {30'd0, v_ack, v_hvalid}, 32'd0);
    ifa.host_dout_ready = 1'b0;
    wait_idle("wrb_idle");
    dsel = 1'b0;

    // Asynchronous reset at byte 300 of a write, then a fresh read
    ifa.sd_lba = 32'h40; ifa.sd_wr = 1'b1;
    wait_req("rst_wr_req");
    start_xfer("rst_wr_start");
    ifa.sd_wr = 1'b0;
    write_stream("rst_wr", 300);
    #2 reset_n = 1'b0;
    #1 check("rst_async", {29'd0, ifa.sd_ack, ifa.host_dout_valid, ifa.busy}, 32'd0);
    ifa.host_dout_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    ifa.sd_lba = 32'h41; ifa.sd_rd = 1'b1;
    wait_req("post_rst_req");
    check("post_rst_lba", v_lba, 32'h41);
    check("post_rst_req_wr", 32'(v_req_wr), 32'd0);
    n_str = 0; str_bad = 0; str_noack = 0;
    start_xfer("post_rst_start");
    ifa.sd_rd = 1'b0;
    feed_bytes(512);
    check("post_rst_ack_fall", 32'(ifa.sd_ack), 32'd0);
    check("post_rst_strobes", 32'(n_str), 32'd512);
    check("post_rst_data", 32'(str_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sd_sector_responder.md
Name: sd_sector_responder

Overview:
- Target (responder) side of the core's sector-request interface (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*), the counterpart of the track-buffer initiator.
- Accepts a one-sector read or write request from the core and forwards it to the host byte-stream port (SPI/ARM side).
- Read: host bytes are written into the core's sector buffer. Write: bytes are fetched from the buffer and streamed to the host.

Parameters:
ACK_GAP, 8, minimum cycles sd_ack stays low between sectors, so the initiator's synchroniser sees each falling edge.
RD_LATENCY, 1, cycles from sd_buff_addr change to valid sd_buff_din (1 or 2 only).

Ports:
clk  in  1  system clock; all state on rising edge
reset_n  in  1  asynchronous active-low reset
sd_lba  in  32  sector address from core
sd_rd  in  1  core read request level
sd_wr  in  1  core write request level
sd_ack  out  1  transfer-in-progress acknowledge to core
sd_buff_addr  out  9  byte index within sector buffer
sd_buff_dout  out  8  read data into core buffer
sd_buff_din  in  8  write data from core buffer
sd_buff_wr  out  1  one-cycle write strobe into core buffer
host_req  out  1  request pending toward host
host_req_wr  out  1  1 = write sector, 0 = read sector
host_req_lba  out  32  latched sector address
host_start  in  1  host accepts request (one-cycle pulse)
host_din  in  8  read byte from host
host_din_valid  in  1  host_din valid this cycle
host_dout  out  8  write byte to host
host_dout_valid  out  1  host_dout valid
host_dout_ready  in  1  host consumes host_dout when valid&ready
host_abort  in  1  terminate current transfer
busy  out  1  any state other than IDLE

Behaviour:
- reset_n low (async): state IDLE; all outputs 0; byte counter 0; gap counter = ACK_GAP (first request accepted at once). Reset mid-transfer drops sd_ack immediately; no further buffer writes.
- States: IDLE, REQ, RD_XFER, WR_FETCH, WR_SEND, GAP.
- IDLE: if sd_rd|sd_wr, latch sd_lba into host_req_lba and set host_req_wr = ~sd_rd (read wins if both asserted). Go to REQ with host_req=1. sd_rd/sd_wr are level-sampled, not edge-detected.
- REQ: hold host_req. On host_start: clear host_req, set sd_ack=1, counter=0. Go to RD_XFER (read) or WR_FETCH (write).
- RD_XFER, per host_din_valid:
  - next cycle: sd_buff_dout=host_din, sd_buff_addr=counter, sd_buff_wr=1 for exactly one cycle; counter increments.
  - The strobe for byte 511 is the last. sd_ack drops the cycle after that strobe. Go to GAP.
  - sd_buff_wr only asserts while sd_ack=1.
- WR_FETCH: drive sd_buff_addr=counter; wait RD_LATENCY cycles; capture sd_buff_din into host_dout; set host_dout_valid. Go to WR_SEND.
- WR_SEND: hold host_dout/host_dout_valid until host_dout_ready.
  - On handshake: counter+1, go to WR_FETCH.
  - If the handshake was for byte 511: drop host_dout_valid and sd_ack, go to GAP.
  - host_dout stays stable while valid & ~ready.
- Counter is 10 bits internally, so byte 511 is detected without wrap-around. sd_buff_addr = counter[8:0].
- GAP: sd_ack=0; count ACK_GAP cycles, then IDLE. Requests are ignored in GAP. A request still high afterwards is served as a new sector.
- host_abort (RD_XFER, WR_FETCH, WR_SEND, REQ):
  - next cycle: sd_ack=0, host_req=0, host_dout_valid=0; go to GAP.
  - Buffer bytes already written stay; later host_din_valid is ignored.
- host_din_valid outside RD_XFER, or host_start outside REQ: ignored.
- busy=1 in every state except IDLE.

Test Plan:
- Read sector: sd_rd=1, sd_lba=0x15; host_start; 512 host bytes i&0xFF, one per 2 cycles -> host_req_lba=0x15, host_req_wr=0; 512 sd_buff_wr pulses at addr 0..511 with dout=addr&0xFF; sd_ack high from the cycle after host_start until the cycle after the last strobe.
- Write sector, backpressure: buffer preloaded with ~addr; sd_wr=1; host_dout_ready toggles 1/0 -> 512 bytes ~0..~511 in order, each held while ready=0; sd_ack falls after byte 511 handshake. Repeat with RD_LATENCY=2.
- Back-to-back: initiator re-asserts sd_rd 5 cycles after sd_ack falls, lba+1 -> second host_req not raised before ACK_GAP=8 low cycles; second lba correct.
- Simultaneous sd_rd=sd_wr=1 in IDLE -> host_req_wr=0 (read served).
- Abort after 100 read bytes -> exactly 100 strobes; sd_ack low next cycle; GAP then IDLE; further host_din_valid produces no strobe.
- reset_n pulse at byte 300 of a write -> sd_ack, host_dout_valid, busy go 0 asynchronously; a new sd_rd after release is served normally.
